adder_result_stage: RTL and testbench
=====================================

// Module: adder_result_stage
// PURPOSE
//   Registered output stage directly downstream of the 32-bit carry-select adder.
//   Captures {sum, cout} together with the operand sign bits it needs.
//   Derives the status flags Z, N, C and V.
//   Hands the result to the ALU writeback over a valid/ready handshake, with a
//   2-entry skid buffer so backpressure never stalls a cycle of adder output.
//   Keeps result and overflow statistics counters.
// PARAMETERS
//   WIDTH     32  datapath width; must match adder width
//   CNT_W     16  width of the statistics counters
// PORTS
//   clk           in   1      single clock; all state on rising edge
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      adder result below is valid this cycle
//   in_ready      out  1      stage can accept; registered = !skid_full
//   a_msb         in   1      operand A sign bit, A[WIDTH-1]
//   b_msb         in   1      operand B sign bit, B[WIDTH-1]
//   sum           in   WIDTH  adder Sum
//   cout          in   1      adder Cout
//   out_valid     out  1      out_* holds a result
//   out_ready     in   1      consumer accepts when out_valid && out_ready
//   out_sum       out  WIDTH  registered sum
//   out_flags     out  4      {Z,N,C,V}
//   result_cnt    out  CNT_W  accepted results; wraps modulo 2^CNT_W
//   ovf_cnt       out  CNT_W  accepted results with V=1; saturates at all-ones
//   clr_stats     in   1      synchronous clear of both counters
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1, out_sum=0,
//     out_flags=0, result_cnt=0, ovf_cnt=0, skid entry empty.
//     Reset mid-transfer discards both entries; no partial output.
//   - Flags are computed at capture from the inputs:
//       Z = (sum==0); N = sum[W-1]; C = cout;
//       V = (a_msb==b_msb) && (sum[W-1]!=a_msb)   (signed add overflow).
//   - Accept: in_fire = in_valid && in_ready. Latency is 1 cycle: the result
//     appears on out_* in the cycle after in_fire.
//   - Emit: out_fire = out_valid && out_ready.
//   - While out_valid && !out_ready, out_sum and out_flags hold stable.
//   - Storage: main register (drives out_*) plus skid register.
//   - States (entries occupied): EMPTY(0), ONE(1), FULL(2).
//       EMPTY: in_fire -> ONE (main loaded).
//       ONE:   in_fire && out_fire  -> ONE (main reloaded; pass-through).
//              in_fire && !out_fire -> FULL (new result to skid).
//              !in_fire && out_fire -> EMPTY.
//       FULL:  in_ready=0; out_fire -> ONE (skid moves to main);
//              in_valid ignored.
//   - Order is strictly FIFO; no result is dropped or duplicated.
//   - Counters update on in_fire. clr_stats has priority over an increment in
//     the same cycle (the counter becomes 0, not 1).
//   - result_cnt wraps from all-ones to 0.
//   - ovf_cnt stays at all-ones once reached.
// CONFIGURATION
//   STICKY_FLAGS_EN defined:
//     - Adds output sticky_cv[1:0] = {C_sticky, V_sticky}.
//     - Each bit is set on in_fire with C=1 or V=1 respectively.
//     - Bits are cleared by clr_stats; set wins over clear in the same cycle.
//     - Reset value is 2'b00.
//   STICKY_FLAGS_EN undefined: port and registers absent; all other
//     behaviour is identical.
// TESTING
//   - Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid=0,
//     in_ready=1, counters=0 immediately.
//   - Single result: sum=0x0000_0000, cout=1, a_msb=b_msb=1, out_ready=1 ->
//     one cycle later out_sum=0, flags=4'b1011 (Z,C,V), result_cnt=1, ovf_cnt=1.
//   - Backpressure: out_ready=0, push 0x11, 0x22, 0x33 -> in_ready drops after
//     0x22 is accepted and 0x33 is held off. Then out_ready=1 -> output order is
//     0x11, 0x22, 0x33 with no gaps once 0x33 is accepted.
//   - Streaming: in_valid=out_ready=1 for 100 cycles -> one output per cycle,
//     in_ready=1 throughout, result_cnt=100.
//   - Saturation/wrap: preload by pushing 2^CNT_W+3 results with V=1 ->
//     ovf_cnt=0xFFFF, result_cnt=3. Then clr_stats=1 together with in_fire ->
//     both counters read 0.
//   - STICKY_FLAGS_EN: push one result with V=1, then ten with V=0 ->
//     sticky_cv=2'b01 persists until clr_stats.

Source files
------------

// File: rtl/adder_result_stage.sv
// adder_result_stage: registered flag/handshake stage after the carry-select adder.
// Optional STICKY_FLAGS_EN adds sticky_cv {C_sticky, V_sticky}.
module adder_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] result_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_stats
`ifdef STICKY_FLAGS_EN
  ,
  output logic [1:0]       sticky_cv
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_sum_q, main_sum_d;
  logic [3:0]       main_flg_q, main_flg_d;
  logic [WIDTH-1:0] skid_sum_q, skid_sum_d;
  logic [3:0]       skid_flg_q, skid_flg_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             in_fire;
  logic             out_fire;
  logic [3:0]       flg_in;
  logic             v_in;

  // Flags of the incoming result and handshake strobes
  always_comb begin
    v_in     = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
    flg_in   = {(sum == '0), sum[WIDTH-1], cout, v_in};
    in_fire  = in_valid && in_ready_q;
    out_fire = (state_q != EMPTY) && out_ready;
  end

  // Two-entry FIFO control: main drives out_*, skid absorbs backpressure
  always_comb begin
    state_d    = state_q;
    main_sum_d = main_sum_q;
    main_flg_d = main_flg_q;
    skid_sum_d = skid_sum_q;
    skid_flg_d = skid_flg_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_sum_d = sum;
          main_flg_d = flg_in;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_sum_d = sum;
          main_flg_d = flg_in;
        end else if (in_fire) begin
          skid_sum_d = sum;
          skid_flg_d = flg_in;
          state_d    = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_sum_d = skid_sum_q;
          main_flg_d = skid_flg_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  // Statistics: clear beats increment, overflow count saturates
  always_comb begin
    res_cnt_d = res_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (clr_stats) begin
      res_cnt_d = '0;
      ovf_cnt_d = '0;
    end else if (in_fire) begin
      res_cnt_d = res_cnt_q + CNT_W'(1);
      if (v_in && (ovf_cnt_q != '1))
        ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  // State, data and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_sum_q <= '0;
      main_flg_q <= '0;
      skid_sum_q <= '0;
      skid_flg_q <= '0;
      res_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_sum_q <= main_sum_d;
      main_flg_q <= main_flg_d;
      skid_sum_q <= skid_sum_d;
      skid_flg_q <= skid_flg_d;
      res_cnt_q  <= res_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

`ifdef STICKY_FLAGS_EN
  logic [1:0] sticky_q, sticky_d;

  // Sticky C/V: a set in the same cycle as a clear wins
  always_comb begin
    sticky_d = clr_stats ? 2'b00 : sticky_q;
    if (in_fire)
      sticky_d = sticky_d | {cout, v_in};
  end

  // Sticky register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 2'b00;
    else        sticky_q <= sticky_d;
  end

  assign sticky_cv = sticky_q;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_sum    = main_sum_q;
  assign out_flags  = main_flg_q;
  assign result_cnt = res_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// tb_adder_result_stage: scoreboard bench for adder_result_stage.
// Optional STICKY_FLAGS_EN also exercises sticky_cv.
module tb_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        a_msb = 1'b0;
  logic        b_msb = 1'b0;
  logic [31:0] sum = '0;
  logic        cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [3:0]  out_flags;
  logic [15:0] result_cnt;
  logic [15:0] ovf_cnt;
  logic        clr_stats = 1'b0;
`ifdef STICKY_FLAGS_EN
  logic [1:0]  sticky_cv;
`endif

  int errors = 0;
  int checks = 0;

  logic [35:0] sb_q[$];
  logic [15:0] m_res;
  logic [15:0] m_ovf;

  always #5 clk = ~clk;

  adder_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_msb(a_msb), .b_msb(b_msb),
    .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags),
    .result_cnt(result_cnt), .ovf_cnt(ovf_cnt),
    .clr_stats(clr_stats)
`ifdef STICKY_FLAGS_EN
    , .sticky_cv(sticky_cv)
`endif
  );

  function automatic logic [3:0] exp_flags(
    input logic [31:0] s, input logic c,
    input logic a, input logic b);
    logic v;
    v = (a == b) && (s[31] != a);
    return {(s == 32'd0), s[31], c, v};
  endfunction

  // Scoreboard and counter model, sampled mid-cycle
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) begin
      sb_q.delete();
      m_res = '0;
      m_ovf = '0;
    end else begin
      checks++;
      if (result_cnt !== m_res || ovf_cnt !== m_ovf) begin
        errors++;
        $display("FAIL counters: got res=%0d ovf=%0d want res=%0d ovf=%0d",
                 result_cnt, ovf_cnt, m_res, m_ovf);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got sum=%h with no result expected", out_sum);
        end else begin
          e = sb_q.pop_front();
          if ({out_sum, out_flags} !== e) begin
            errors++;
            $display("FAIL sb_data: got %h/%b want %h/%b",
                     out_sum, out_flags, e[35:4], e[3:0]);
          end
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back({sum, exp_flags(sum, cout, a_msb, b_msb)});
      if (clr_stats) begin
        m_res = '0;
        m_ovf = '0;
      end else if (in_valid && in_ready) begin
        m_res = m_res + 16'd1;
        if (exp_flags(sum, cout, a_msb, b_msb) & 4'b0001)
          if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] s,
                       input logic c, input logic a, input logic b);
    in_valid = v;
    sum      = s;
    cout     = c;
    a_msb    = a;
    b_msb    = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1, 32'hDEAD_BEEF, 1, 1, 0);
    step();
    drive(1, 32'h1234_5678, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        result_cnt !== 16'd0 || ovf_cnt !== 16'd0 ||
        out_sum !== 32'd0 || out_flags !== 4'd0) begin
      errors++;
      $display("FAIL reset: got v=%b r=%b cnt=%0d ovf=%0d sum=%h f=%b want 0 1 0 0 0 0",
               out_valid, in_ready, result_cnt, ovf_cnt, out_sum, out_flags);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1, 32'h0, 1, 1, 1);
    step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd0 || out_flags !== 4'b1011 ||
        result_cnt !== 16'd1 || ovf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single: got v=%b sum=%h f=%b cnt=%0d ovf=%0d want 1 0 1011 1 1",
               out_valid, out_sum, out_flags, result_cnt, ovf_cnt);
    end
    step();
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1, 32'h8000_0001, 0, 0, 0); step();
    drive(1, 32'h7FFF_FFFF, 1, 1, 1); step();
    drive(1, 32'h0000_0010, 1, 1, 0); step();
    drive(1, 32'hFFFF_FFFF, 0, 1, 0); step();
    drive(1, 32'h0000_0000, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0);
    step();
    step();
  endtask

  task automatic test_backpressure();
    logic acc;
    int   nv;
    out_ready = 1'b0;
    drive(1, 32'h11, 0, 0, 0); step();
    drive(1, 32'h22, 0, 0, 0); step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_drop: got in_ready=%b want 0", in_ready);
    end
    drive(1, 32'h33, 0, 0, 0);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_sum !== 32'h11) begin
      errors++;
      $display("FAIL bp_hold: got in_ready=%b out_sum=%h want 0 11",
               in_ready, out_sum);
    end
    out_ready = 1'b1;
    acc = 1'b0;
    nv  = 0;
    for (int i = 0; i < 6 && !acc; i++) begin
      acc = in_ready;
      step();
      if (out_valid) nv++;
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (!acc || nv < 2 || out_sum !== 32'h33) begin
      errors++;
      $display("FAIL bp_accept: got acc=%b valid_cycles=%0d sum=%h want 1 >=2 33",
               acc, nv, out_sum);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: got in_ready=%b out_valid=%b want 1 1",
                 i, in_ready, out_valid);
      end
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (result_cnt !== 16'd100) begin
      errors++;
      $display("FAIL stream_cnt: got %0d want 100", result_cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    out_ready = 1'b1;
    drive(1, 32'h8000_0000, 0, 0, 0);
    for (int i = 0; i < 65539; i++) step();
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ovf_cnt !== 16'hFFFF || result_cnt !== 16'd3) begin
      errors++;
      $display("FAIL saturate: got ovf=%h res=%0d want ffff 3", ovf_cnt, result_cnt);
    end
    drive(1, 32'h8000_0000, 0, 0, 0);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (ovf_cnt !== 16'd0 || result_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_prio: got ovf=%0d res=%0d want 0 0", ovf_cnt, result_cnt);
    end
    step();
  endtask

`ifdef STICKY_FLAGS_EN
  task automatic test_sticky();
    out_ready = 1'b1;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    drive(1, 32'h8000_0000, 0, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h100 + 32'(i), 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sticky_cv !== 2'b01) begin
      errors++;
      $display("FAIL sticky_hold: got %b want 01", sticky_cv);
    end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++;
    if (sticky_cv !== 2'b00) begin
      errors++;
      $display("FAIL sticky_clr: got %b want 00", sticky_cv);
    end
    clr_stats = 1'b1;
    drive(1, 32'h0, 1, 0, 0);
    step();
    clr_stats = 1'b0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (sticky_cv !== 2'b10) begin
      errors++;
      $display("FAIL sticky_set_wins: got %b want 10", sticky_cv);
    end
    step();
  endtask
`endif

  task automatic test_drain();
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (4) step();
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d out_valid=%b want 0 0",
               sb_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_streaming();
    test_saturation();
`ifdef STICKY_FLAGS_EN
    test_sticky();
`endif
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
